// File: rtl/rd_frame_buf_pkg.sv
// Shared sizing constants for the read-path frame/line buffer.
package rd_frame_buf_pkg;
  localparam int RFB_DATA_WIDTH = 128;
  localparam int RFB_ADDR_WIDTH = 10;
  localparam bit RFB_OUT_REG    = 1'b0;
endpackage

// File: rtl/rd_frame_buf_port.sv
// One port slice: reset-qualified write enable and the read output register(s).
module rd_frame_buf_port
  import rd_frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = RFB_DATA_WIDTH,
  parameter bit OUT_REG    = RFB_OUT_REG
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] mem_word_i,
  output logic                  wr_gnt_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] rd1_q;

  // Writes sampled while reset is held are dropped, not deferred.
  assign wr_gnt_o = wr_en_i & rstn;

  // mem_word_i is the pre-edge array word, which gives read-first behaviour.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd1_q <= '0;
    else       rd1_q <= mem_word_i;
  end

  if (OUT_REG) begin : g_oreg
    logic [DATA_WIDTH-1:0] rd2_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rd2_q <= '0;
      else       rd2_q <= rd1_q;
    end
    assign rd_data_o = rd2_q;
  end else begin : g_noreg
    assign rd_data_o = rd1_q;
  end

endmodule

// File: rtl/rd_frame_buf.sv
// True dual-port line buffer: port A fills from DDR bursts, port B drains to the output side.
module rd_frame_buf
  import rd_frame_buf_pkg::*;
#(
  parameter int DATA_WIDTH = RFB_DATA_WIDTH,
  parameter int ADDR_WIDTH = RFB_ADDR_WIDTH,
  parameter bit OUT_REG    = RFB_OUT_REG
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  input  logic                  a_wr_en,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  input  logic                  b_wr_en,
  output logic [DATA_WIDTH-1:0] b_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  a_gnt;
  logic                  b_gnt;
  logic                  b_wr_d;
  logic [DATA_WIDTH-1:0] a_word;
  logic [DATA_WIDTH-1:0] b_word;

  assign a_word = mem_q[a_addr];
  assign b_word = mem_q[b_addr];

  // Port A owns an address both ports write in the same cycle.
  assign b_wr_d = b_gnt & ~(a_gnt & (a_addr == b_addr));

  always_ff @(posedge clk) begin
    if (a_gnt)  mem_q[a_addr] <= a_wr_data;
    if (b_wr_d) mem_q[b_addr] <= b_wr_data;
  end

  rd_frame_buf_port #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_port_a (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (a_wr_en),
    .mem_word_i (a_word),
    .wr_gnt_o   (a_gnt),
    .rd_data_o  (a_rd_data)
  );

  rd_frame_buf_port #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_port_b (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en_i    (b_wr_en),
    .mem_word_i (b_word),
    .wr_gnt_o   (b_gnt),
    .rd_data_o  (b_rd_data)
  );

endmodule

// File: tb/tb_rd_frame_buf.sv
// Directed scoreboard bench: latency-1 and latency-2 builds driven by the same stimulus.
module tb_rd_frame_buf;

  logic         clk = 1'b0;
  logic         rstn;
  logic [9:0]   a_addr, b_addr;
  logic [127:0] a_wr_data, b_wr_data;
  logic         a_wr_en, b_wr_en;
  logic [127:0] a_rd_data, b_rd_data;
  logic [127:0] a_rd_data2, b_rd_data2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic         av;
    logic [127:0] ad;
    logic         bv;
    logic [127:0] bd;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  logic [127:0] mm [1024];
  bit           mv [1024];

  always #5 clk = ~clk;

  rd_frame_buf #(.DATA_WIDTH(128), .ADDR_WIDTH(10), .OUT_REG(1'b0)) dut (
    .clk(clk), .rstn(rstn),
    .a_addr(a_addr), .a_wr_data(a_wr_data), .a_wr_en(a_wr_en), .a_rd_data(a_rd_data),
    .b_addr(b_addr), .b_wr_data(b_wr_data), .b_wr_en(b_wr_en), .b_rd_data(b_rd_data)
  );

  rd_frame_buf #(.DATA_WIDTH(128), .ADDR_WIDTH(10), .OUT_REG(1'b1)) dut2 (
    .clk(clk), .rstn(rstn),
    .a_addr(a_addr), .a_wr_data(a_wr_data), .a_wr_en(a_wr_en), .a_rd_data(a_rd_data2),
    .b_addr(b_addr), .b_wr_data(b_wr_data), .b_wr_en(b_wr_en), .b_rd_data(b_rd_data2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input exp_t e, input logic [127:0] oa, input logic [127:0] ob);
    if (e.av) chk({tag, "_a"}, oa, e.ad);
    if (e.bv) chk({tag, "_b"}, ob, e.bd);
  endtask

  // Drive one cycle; expectations come from the reference model before its update.
  task automatic step(input string tag,
                      input logic awe, input logic [9:0] aad, input logic [127:0] awd,
                      input logic bwe, input logic [9:0] bad, input logic [127:0] bwd);
    exp_t e;
    a_wr_en = awe; a_addr = aad; a_wr_data = awd;
    b_wr_en = bwe; b_addr = bad; b_wr_data = bwd;
    e.av = mv[aad]; e.ad = mm[aad];
    e.bv = mv[bad]; e.bd = mm[bad];
    q1.push_back(e);
    q2.push_back(e);
    if (awe) begin mm[aad] = awd; mv[aad] = 1'b1; end
    if (bwe && !(awe && aad == bad)) begin mm[bad] = bwd; mv[bad] = 1'b1; end
    @(posedge clk); #1;
    chk_e({tag, "_l1"}, q1.pop_front(), a_rd_data, b_rd_data);
    if (q2.size() == 2) chk_e({tag, "_l2"}, q2.pop_front(), a_rd_data2, b_rd_data2);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a1"}, a_rd_data, '0);
    chk({tag, "_b1"}, b_rd_data, '0);
    chk({tag, "_a2"}, a_rd_data2, '0);
    chk({tag, "_b2"}, b_rd_data2, '0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mv[i] = 1'b0;

    // Reset held with write traffic: outputs stay zero, writes are dropped.
    rstn = 1'b0;
    a_wr_en = 1'b1; a_addr = 10'd3; a_wr_data = {4{32'hDEADBEEF}};
    b_wr_en = 1'b1; b_addr = 10'd4; b_wr_data = {4{32'hCAFEF00D}};
    #2 chk_zero("rst_init");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      a_addr = 10'(c + 10); b_addr = 10'(c + 20);
      chk_zero("rst_hold");
    end
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    @(negedge clk); rstn = 1'b1;

    step("pre_wr", 1'b1, 10'd3, 128'h3333, 1'b0, 10'd3, '0);
    step("pre_rd", 1'b0, 10'd3, '0, 1'b0, 10'd3, '0);
    step("pre_rd2", 1'b0, 10'd3, '0, 1'b0, 10'd3, '0);

    // Fill from A while B trails one address behind.
    for (int i = 0; i < 1024; i++)
      step("fill", 1'b1, 10'(i), 128'(i), 1'b0, 10'(i - 1), '0);

    // Drain on B back-to-back, wrapping 1023 -> 0.
    for (int i = 0; i <= 1024; i++)
      step("drain", 1'b0, 10'(1023 - (i % 1024)), '0, 1'b0, 10'(i), '0);

    // Same-port read-first.
    step("rf_init", 1'b1, 10'd5, {8{16'hAAAA}}, 1'b0, 10'd0, '0);
    step("rf_wr",   1'b1, 10'd5, {8{16'h5555}}, 1'b0, 10'd1, '0);
    chk("rf_old", a_rd_data, {8{16'hAAAA}});
    step("rf_rd",   1'b0, 10'd5, '0, 1'b0, 10'd2, '0);
    chk("rf_new", a_rd_data, {8{16'h5555}});

    // Cross-port: B reading the address A writes sees old contents.
    step("xp_init", 1'b1, 10'd7, '0, 1'b0, 10'd6, '0);
    step("xp_wr",   1'b1, 10'd7, 128'h1234, 1'b0, 10'd7, '0);
    chk("xp_old", b_rd_data, '0);
    step("xp_rd",   1'b0, 10'd8, '0, 1'b0, 10'd7, '0);
    chk("xp_new", b_rd_data, 128'h1234);

    // Collision: A wins.
    step("col_wr", 1'b1, 10'd9, {16{8'h11}}, 1'b1, 10'd9, {16{8'h22}});
    step("col_rd", 1'b0, 10'd9, '0, 1'b0, 10'd9, '0);
    chk("col_a", a_rd_data, {16{8'h11}});
    chk("col_b", b_rd_data, {16{8'h11}});
    step("col_rd2", 1'b0, 10'd0, '0, 1'b0, 10'd0, '0);

    // Asynchronous reset mid-stream clears every pipeline stage at once.
    for (int i = 100; i < 104; i++)
      step("mid", 1'b0, 10'(i), '0, 1'b0, 10'(i + 1), '0);
    #2 rstn = 1'b0;
    #1 chk_zero("arst");
    a_wr_en = 1'b1; a_addr = 10'd100; a_wr_data = {4{32'hBADBAD00}};
    b_wr_en = 1'b1; b_addr = 10'd101; b_wr_data = {4{32'hBADBAD11}};
    @(posedge clk); #1;
    chk_zero("arst_hold");
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    q1.delete(); q2.delete();
    rstn = 1'b1;
    step("post_rst", 1'b0, 10'd100, '0, 1'b0, 10'd101, '0);
    chk("post_rst_a2", a_rd_data2, '0);
    chk("post_rst_b2", b_rd_data2, '0);
    step("post_rst2", 1'b0, 10'd102, '0, 1'b0, 10'd1023, '0);
    step("post_rst3", 1'b0, 10'd0, '0, 1'b0, 10'd0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_frame_buf.md
Name: rd_frame_buf

Overview:
- True dual-port synchronous RAM line buffer: 1024 words x 128 bits, two independent read/write ports (A, B) on one shared clock.
- In the PCIe zero-copy read path, port A takes DDR burst data, port B is read sequentially by the video/PCIe output side.
- Memory array is not reset; only output data registers are.

Parameters:
- DATA_WIDTH, 128, word width of both ports.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH (1024).
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output pipeline register, latency 2 cycles.

Ports:
- clk  input  1  single clock for both ports, rising edge.
- rstn  input  1  asynchronous active-low reset; clears output registers only.
- a_addr  input  ADDR_WIDTH  port A word address.
- a_wr_data  input  DATA_WIDTH  port A write data.
- a_wr_en  input  1  port A write enable.
- a_rd_data  output  DATA_WIDTH  port A read data.
- b_addr  input  ADDR_WIDTH  port B word address.
- b_wr_data  input  DATA_WIDTH  port B write data.
- b_wr_en  input  1  port B write enable.
- b_rd_data  output  DATA_WIDTH  port B read data.

Behaviour:
- Reset: rstn low asynchronously forces a_rd_data and b_rd_data (and OUT_REG stage registers) to 0. Reset has no effect on array contents. While rstn is low, writes are ignored. Release is synchronous to the next clk edge.
- Write: at rising clk with X_wr_en=1, mem[X_addr] <= X_wr_data.
- Read: every cycle (no read enable), each port samples X_addr.
  - OUT_REG=0: X_rd_data valid 1 cycle after the address.
  - OUT_REG=1: X_rd_data valid 2 cycles after the address.
- Same-port read-during-write: read-first. X_rd_data returns the old contents of X_addr; new data is visible on the next read.
- Cross-port read of an address being written in the same cycle also returns the old contents.
- Both ports write the same address in the same cycle: port A wins; port B's write is discarded.
- Address wrap: 10-bit address; callers wrap 1023 -> 0 naturally. No out-of-range addresses exist.
- No flags, no handshake; reads and writes on both ports are accepted every cycle.
- Uninitialised words read as don't-care in synthesis; the bench treats them as unknown.

Decomposition:
- No shared package needed. Shared constants are DATA_WIDTH=128 and ADDR_WIDTH=10, which may live in the team's existing video/PCIe params package if present.
- One optional sub-module: rd_frame_buf_port, one per-port read/write plus output-register slice, instantiated twice (A, B).
- The array itself stays in the top so the A-over-B write priority is resolved in one always block.

Test Plan:
- Reset: hold rstn=0 with pattern on addresses -> a_rd_data = b_rd_data = 0. Release, read a preloaded address -> data appears after 1 cycle (OUT_REG=0).
- Sequential fill/drain: A writes addr 0..1023 with data = {96'h0, 22'h0, addr}. B reads 0..1023 back-to-back -> b_rd_data at cycle n+1 equals pattern of addr n, including wrap 1023 -> 0.
- Read-first: mem[5]=AAAA..; same cycle A writes 5 with 5555.. and A reads 5 -> a_rd_data=AAAA..; next cycle read 5 -> 5555...
- Cross-port: A writes addr 7 = 0x1234 while B reads 7 (old 0) -> b_rd_data=0. Next read -> 0x1234.
- Collision: A and B both write addr 9 (A=0x11.., B=0x22..) -> subsequent read of 9 on either port = 0x11...
- OUT_REG=1 build: repeat the fill/drain scenario -> data lags address by exactly 2 cycles. Async reset mid-stream clears both pipeline stages immediately.
